// File: rtl/scan_capture.sv
// Receive-side deserializer for the scan stream: samples scan_in LSB first after each
// rising edge of en, presents the word with a one-cycle valid pulse, counts frames.
module scan_capture #(
    parameter int WIDTH = 19,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             scan_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             restart_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic              last_en_q, last_en_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              restart_err_q, restart_err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              rise;

    assign rise = en & ~last_en_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path can leave it unassigned (no latches).
        state_d       = state_q;
        last_en_d     = en;
        bitcnt_d      = bitcnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        valid_d       = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        restart_err_d = clear_err ? 1'b0 : restart_err_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // A new rise always wins, even on the edge that would take the last bit.
                if (rise) begin
                    bitcnt_d      = '0;
                    restart_err_d = 1'b1;
                end else begin
                    shift_d[bitcnt_q] = scan_in;
                    bitcnt_d          = bitcnt_q + BW'(1);
                    if (bitcnt_q == BW'(WIDTH - 1)) begin
                        data_out_d  = shift_d;
                        valid_d     = 1'b1;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        bitcnt_d    = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_en_q     <= 1'b0;
            bitcnt_q      <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            valid_q       <= 1'b0;
            restart_err_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_en_q     <= last_en_d;
            bitcnt_q      <= bitcnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            restart_err_q <= restart_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid       = valid_q;
    assign busy        = (state_q == SHIFT);
    assign restart_err = restart_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_scan_capture.sv
// Bench for scan_capture: a serializer model drives scan_in, expected frames go into a
// queue, and a negedge monitor pops and compares whenever valid is high.
module tb_scan_capture;

    localparam int W = 19;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         scan_in;
    logic         clear_err;
    logic [W-1:0] data_out;
    logic         valid;
    logic         busy;
    logic         restart_err;
    logic [C-1:0] frame_cnt;

    typedef struct {
        logic [W-1:0] data;
        logic [C-1:0] cnt;
    } exp_t;

    exp_t         exp_q[$];
    logic [C-1:0] exp_cnt;
    int           n_cmp = 0;
    int           n_err = 0;

    scan_capture #(.WIDTH(W), .CNT_W(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .scan_in    (scan_in),
        .clear_err  (clear_err),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .restart_err(restart_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle, compare every valid pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
                check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serializer model: en rises into edge E0, bit k is driven during the cycle after E0+k.
    task automatic send_bits(input logic [W-1:0] w, input int nbits, input bit clr,
                             input bit chk_busy);
        en        = 1'b1;
        clear_err = clr;
        tick();
        en        = 1'b0;
        clear_err = 1'b0;
        if (chk_busy) check("busy_after_e0", 32'(busy), 32'd1);
        for (int k = 0; k < nbits; k++) begin
            scan_in = w[k];
            tick();
        end
        scan_in = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] w, input bit clr, input bit chk_busy);
        exp_t e;
        exp_cnt = exp_cnt + C'(1);
        e.data  = w;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        send_bits(w, W, clr, chk_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_restart_err"}, 32'(restart_err), 32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #2;
        check_reset_state("rst");
        exp_cnt = '0;
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [W-1:0] w;

        rst_n     = 1'b0;
        en        = 1'b0;
        scan_in   = 1'b0;
        clear_err = 1'b0;
        exp_cnt   = '0;
        idle(2);
        check_reset_state("init");
        rst_n = 1'b1;
        tick();

        // Single frame
        check("busy_idle", 32'(busy), 32'd0);
        send(19'h5A5A5, 1'b0, 1'b1);
        check("busy_done", 32'(busy), 32'd0);
        check("valid_after_e0p19", 32'(valid), 32'd1);
        check("restart_err_single", 32'(restart_err), 32'd0);
        idle(3);

        // LSB-first: frame starts 25 cycles apart
        send(19'h00001, 1'b0, 1'b0);
        idle(5);
        send(19'h40000, 1'b0, 1'b0);
        idle(3);
        check("frame_cnt_lsb", 32'(frame_cnt), 32'd3);

        // Restart mid-frame at E0+10
        send_bits(19'h7FFFF, 9, 1'b0, 1'b0);
        send(19'h12345, 1'b0, 1'b0);
        check("restart_err_mid", 32'(restart_err), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("restart_err_cleared", 32'(restart_err), 32'd0);
        idle(2);

        // Restart exactly on the last-bit edge E0+19
        send_bits(19'h2AAAA, W - 1, 1'b0, 1'b0);
        send(19'h0F0F0, 1'b0, 1'b0);
        check("restart_err_last", 32'(restart_err), 32'd1);
        check("frame_cnt_last", 32'(frame_cnt), 32'd5);

        // clear_err on the same edge as a restart: set wins
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("restart_err_clr2", 32'(restart_err), 32'd0);
        send_bits(19'h13579, 5, 1'b0, 1'b0);
        send(19'h2468A, 1'b1, 1'b0);
        check("restart_err_set_wins", 32'(restart_err), 32'd1);
        idle(2);

        // Reset mid-frame at E0+7, then a clean frame
        send_bits(19'h55555, 7, 1'b0, 1'b0);
        do_reset();
        send(19'h7FFFF, 1'b0, 1'b0);
        check("restart_err_post_rst", 32'(restart_err), 32'd0);
        check("frame_cnt_post_rst", 32'(frame_cnt), 32'd1);
        idle(2);

        // Counter wrap with back-to-back frames
        do_reset();
        for (int i = 0; i < 256; i++) begin
            w = W'($urandom);
            send(w, 1'b0, 1'b0);
        end
        idle(2);
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        check("restart_err_wrap", 32'(restart_err), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
